// File: rtl/int_mem_pkg.sv
// Shared FSM encoding and address helpers for the internal SRAM port arbiter.
package int_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } arb_state_e;

  // Number of low byte-address bits that select a byte within one SRAM word.
  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/int_mem_rd_buf.sv
// Two-entry FIFO holding SRAM read data until the read-data consumer accepts it.
module int_mem_rd_buf #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  valid_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

  always_comb begin
    occ_d = occ_q;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      occ_q <= occ_d;
      if (do_push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Payload storage needs no reset; occupancy qualifies it.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign valid_o     = (occ_q != 2'd0);
  assign occ_o       = occ_q;

  int_mem_rd_buf_chk u_chk (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .occ_i (occ_q)
  );

endmodule

// File: rtl/int_mem_rd_buf_chk.sv
// Occupancy invariant for the read-return buffer.
module int_mem_rd_buf_chk (
  input logic       clk_i,
  input logic       rst_i,
  input logic [1:0] occ_i
);

  occ_never_over_two: assert property (@(posedge clk_i) disable iff (rst_i) occ_i <= 2'd2);

endmodule

// File: rtl/int_mem_port_arb.sv
// Round-robin, burst-granular arbiter sharing one single-port SRAM between
// the write stream and the read stream, with a 2-entry read-return buffer.
module int_mem_port_arb
  import int_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AW     = 12
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    WAddrValid,
  output logic                    WAddrReady,
  input  logic [31:0]             WAddrOut,
  input  logic                    WAddrLast,
  input  logic [DATA_WIDTH-1:0]   WDataIn,
  input  logic [DATA_WIDTH/8-1:0] WStrbIn,
  input  logic                    RAddrValid,
  output logic                    RAddrReady,
  input  logic [31:0]             RAddrOut,
  input  logic                    RAddrLast,
  output logic [DATA_WIDTH-1:0]   RDataOut,
  output logic                    RDataValid,
  input  logic                    RDataReady,
  output logic                    MemCs,
  output logic                    MemWe,
  output logic [MEM_AW-1:0]       MemAddr,
  output logic [DATA_WIDTH-1:0]   MemWData,
  output logic [DATA_WIDTH/8-1:0] MemWStrb,
  input  logic [DATA_WIDTH-1:0]   MemRData
);

  localparam int BYTE_SHIFT = byte_shift(DATA_WIDTH);

  arb_state_e  state_q;
  arb_state_e  state_d;
  logic        last_wr_q;
  logic        last_wr_d;
  logic        inflight_q;
  logic        rd_issue;
  logic        rd_pop;
  logic        rd_space;
  logic [1:0]  buf_occ;
  logic [2:0]  occ_sum;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{WAddrOut, RAddrOut};

  // Space counts data already buffered plus the read still in the SRAM pipe.
  assign rd_pop   = RDataValid && RDataReady;
  assign occ_sum  = {1'b0, buf_occ} + {2'b00, inflight_q} - {2'b00, rd_pop};
  assign rd_space = (occ_sum < 3'd2);

  assign MemAddr  = (state_q == RD_BURST) ? RAddrOut[BYTE_SHIFT+MEM_AW-1:BYTE_SHIFT]
                                          : WAddrOut[BYTE_SHIFT+MEM_AW-1:BYTE_SHIFT];
  assign MemWData = WDataIn;
  assign MemWStrb = WStrbIn;

  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    WAddrReady = 1'b0;
    RAddrReady = 1'b0;
    MemCs      = 1'b0;
    MemWe      = 1'b0;
    rd_issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (WAddrValid && (!RAddrValid || !last_wr_q)) begin
          state_d   = WR_BURST;
          last_wr_d = 1'b1;
        end else if (RAddrValid) begin
          state_d   = RD_BURST;
          last_wr_d = 1'b0;
        end else begin
          state_d   = IDLE;
        end
      end
      WR_BURST: begin
        WAddrReady = 1'b1;
        if (WAddrValid) begin
          MemCs   = 1'b1;
          MemWe   = 1'b1;
          state_d = WAddrLast ? IDLE : WR_BURST;
        end else begin
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        RAddrReady = rd_space;
        if (RAddrValid && rd_space) begin
          MemCs    = 1'b1;
          rd_issue = 1'b1;
          state_d  = RAddrLast ? IDLE : RD_BURST;
        end else begin
          state_d  = RD_BURST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      last_wr_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      inflight_q <= rd_issue;
    end
  end

  int_mem_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_buf (
    .clk_i       (ACLK),
    .rst_i       (ARESET),
    .push_i      (inflight_q),
    .push_data_i (MemRData),
    .pop_i       (rd_pop),
    .head_data_o (RDataOut),
    .valid_o     (RDataValid),
    .occ_o       (buf_occ)
  );

endmodule

// File: tb/tb_int_mem_port_arb.sv
// Directed bench for int_mem_port_arb: behavioural SRAM, queue-based reference
// model checked every cycle, and literal expectations per scenario.
module tb_int_mem_port_arb;

  localparam int DW = 128;
  localparam int AW = 12;
  localparam int BS = 4;
  localparam int SW = DW / 8;
  localparam int OWN_NONE = 0;
  localparam int OWN_WR   = 1;
  localparam int OWN_RD   = 2;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          WAddrValid, WAddrReady, WAddrLast;
  logic [31:0]   WAddrOut;
  logic [DW-1:0] WDataIn;
  logic [SW-1:0] WStrbIn;
  logic          RAddrValid, RAddrReady, RAddrLast;
  logic [31:0]   RAddrOut;
  logic [DW-1:0] RDataOut;
  logic          RDataValid, RDataReady;
  logic          MemCs, MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [SW-1:0] MemWStrb;
  logic [DW-1:0] MemRData;

  always #5 ACLK = ~ACLK;

  int_mem_port_arb #(.DATA_WIDTH(DW), .MEM_AW(AW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .WAddrValid(WAddrValid), .WAddrReady(WAddrReady), .WAddrOut(WAddrOut),
    .WAddrLast(WAddrLast), .WDataIn(WDataIn), .WStrbIn(WStrbIn),
    .RAddrValid(RAddrValid), .RAddrReady(RAddrReady), .RAddrOut(RAddrOut),
    .RAddrLast(RAddrLast), .RDataOut(RDataOut), .RDataValid(RDataValid),
    .RDataReady(RDataReady), .MemCs(MemCs), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemWStrb(MemWStrb), .MemRData(MemRData)
  );

  // Single-port SRAM with byte enables and one-cycle read latency.
  logic [DW-1:0] sram [1 << AW];
  always @(posedge ACLK) begin
    if (MemCs && MemWe) begin
      for (int b = 0; b < SW; b++)
        if (MemWStrb[b]) sram[MemAddr][b*8 +: 8] <= MemWData[b*8 +: 8];
    end else if (MemCs) begin
      MemRData <= sram[MemAddr];
    end
  end

  typedef struct { logic [31:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } wbeat_t;
  typedef struct { logic [31:0] addr; logic last; } rbeat_t;

  wbeat_t        wq[$];
  rbeat_t        rq[$];
  int            checks, errors;
  int            cyc, r_delay, rdy_from;
  int            w_acc[$], r_acc[$], d_cyc[$];
  logic [DW-1:0] d_val[$];
  logic [AW-1:0] w_maddr[$];

  // Reference model: who owns the port, tie-break memory, buffered data, pending read.
  int            m_owner;
  bit            m_last_wr;
  logic [DW-1:0] m_q[$];
  bit            m_pend;
  logic [DW-1:0] m_pend_data;

  function automatic logic [DW-1:0] wdat(input int k);
    return {4{32'hC0DE_0000 + 32'(k)}};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_owner   = OWN_NONE;
    m_last_wr = 1'b0;
    m_q.delete();
    m_pend    = 1'b0;
  endtask

  // Called at the falling edge: compare outputs, then advance the model one clock.
  task automatic model_step();
    int n_held;
    bit space, e_we, issue, e_rvalid;
    n_held   = m_q.size() + (m_pend ? 1 : 0) - ((m_q.size() != 0 && RDataReady) ? 1 : 0);
    space    = (n_held < 2);
    e_rvalid = (m_q.size() != 0);
    e_we     = (m_owner == OWN_WR) && WAddrValid;
    issue    = (m_owner == OWN_RD) && RAddrValid && space;
    chk1("WAddrReady", WAddrReady, m_owner == OWN_WR);
    chk1("RAddrReady", RAddrReady, (m_owner == OWN_RD) && space);
    chk1("MemCs", MemCs, e_we || issue);
    chk1("MemWe", MemWe, e_we);
    if (e_we) begin
      chkw("MemAddr_wr", DW'(MemAddr), DW'(WAddrOut[BS+AW-1:BS]));
      chkw("MemWData", MemWData, WDataIn);
      chkw("MemWStrb", DW'(MemWStrb), DW'(WStrbIn));
    end
    if (issue) chkw("MemAddr_rd", DW'(MemAddr), DW'(RAddrOut[BS+AW-1:BS]));
    chk1("RDataValid", RDataValid, e_rvalid);
    if (e_rvalid) chkw("RDataOut", RDataOut, m_q[0]);
    if (e_rvalid && RDataReady) void'(m_q.pop_front());
    if (m_pend) m_q.push_back(m_pend_data);
    m_pend = issue;
    if (issue) m_pend_data = sram[RAddrOut[BS+AW-1:BS]];
    case (m_owner)
      OWN_NONE: begin
        if (WAddrValid && (!RAddrValid || !m_last_wr)) begin
          m_owner = OWN_WR; m_last_wr = 1'b1;
        end else if (RAddrValid) begin
          m_owner = OWN_RD; m_last_wr = 1'b0;
        end
      end
      OWN_WR:  if (WAddrValid && WAddrLast) m_owner = OWN_NONE;
      default: if (issue && RAddrLast) m_owner = OWN_NONE;
    endcase
  endtask

  task automatic push_w(input logic [31:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    wbeat_t b;
    b.addr = a; b.data = d; b.strb = s; b.last = l;
    wq.push_back(b);
  endtask

  task automatic push_r(input logic [31:0] a, input logic l);
    rbeat_t b;
    b.addr = a; b.last = l;
    rq.push_back(b);
  endtask

  task automatic add_wr_burst(input logic [31:0] base, input int n, input int k0);
    for (int i = 0; i < n; i++) push_w(base + 32'(i * 16), wdat(k0 + i), {SW{1'b1}}, i == n - 1);
  endtask

  task automatic add_rd_burst(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) push_r(base + 32'(i * 16), i == n - 1);
  endtask

  // Present queued beats cycle by cycle, logging accepts and returned data.
  task automatic run(input int max_c, input bit must_end);
    bit aw, ar, done;
    cyc = 0;
    w_acc.delete(); r_acc.delete(); d_cyc.delete(); d_val.delete(); w_maddr.delete();
    while ((wq.size() != 0 || rq.size() != 0 || m_q.size() != 0 || m_pend) && cyc < max_c) begin
      WAddrValid = (wq.size() != 0);
      if (wq.size() != 0) begin
        WAddrOut = wq[0].addr; WDataIn = wq[0].data; WStrbIn = wq[0].strb; WAddrLast = wq[0].last;
      end
      RAddrValid = (rq.size() != 0) && (cyc >= r_delay);
      if (rq.size() != 0) begin
        RAddrOut = rq[0].addr; RAddrLast = rq[0].last;
      end
      RDataReady = (cyc >= rdy_from);
      @(negedge ACLK);
      aw = WAddrValid && WAddrReady;
      ar = RAddrValid && RAddrReady;
      if (aw) begin w_acc.push_back(cyc); w_maddr.push_back(MemAddr); end
      if (ar) r_acc.push_back(cyc);
      if (RDataValid && RDataReady) begin d_cyc.push_back(cyc); d_val.push_back(RDataOut); end
      model_step();
      if (aw) void'(wq.pop_front());
      if (ar) void'(rq.pop_front());
      @(posedge ACLK); #1;
      cyc++;
    end
    if (must_end) begin
      done = (wq.size() == 0 && rq.size() == 0 && m_q.size() == 0 && !m_pend);
      chk1("run_completed_in_budget", done, 1'b1);
      wq.delete(); rq.delete();
    end
  endtask

  initial begin
    logic [DW-1:0] ta, tb, texp;
    int n_early;
    checks = 0; errors = 0; r_delay = 0; rdy_from = 0;
    ARESET = 1'b1; WAddrValid = 1'b0; WAddrOut = 32'h0; WAddrLast = 1'b0;
    WDataIn = '0; WStrbIn = '0; RAddrValid = 1'b0; RAddrOut = 32'h0;
    RAddrLast = 1'b0; RDataReady = 1'b0;
    m_reset();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk1("rst_WAddrReady", WAddrReady, 1'b0);
    chk1("rst_RAddrReady", RAddrReady, 1'b0);
    chk1("rst_RDataValid", RDataValid, 1'b0);
    chk1("rst_MemCs", MemCs, 1'b0);
    chk1("rst_MemWe", MemWe, 1'b0);
    model_step();
    @(posedge ACLK); #1;

    // Tie after reset: write burst wins, one bubble, then the read burst.
    add_wr_burst(32'h100, 4, 0);
    add_rd_burst(32'h100, 4);
    run(40, 1'b1);
    chki("tie_w_count", w_acc.size(), 4);
    chki("tie_r_count", r_acc.size(), 4);
    chki("tie_d_count", d_val.size(), 4);
    if (w_acc.size() == 4 && r_acc.size() == 4 && d_val.size() == 4) begin
      chki("tie_w_first_cyc", w_acc[0], 1);
      chki("tie_w_last_cyc", w_acc[3], 4);
      chki("tie_r_first_cyc", r_acc[0], 6);
      chki("tie_r_last_cyc", r_acc[3], 9);
      chki("tie_d_first_cyc", d_cyc[0], 8);
      for (int k = 0; k < 4; k++) chkw("tie_rdata", d_val[k], wdat(k));
    end

    // Single write to byte address 0x40 lands on word 4 after an arbitration bubble.
    push_w(32'h40, wdat(40), {SW{1'b1}}, 1'b1);
    run(10, 1'b1);
    chki("sw_count", w_acc.size(), 1);
    if (w_acc.size() == 1) begin
      chki("sw_accept_cyc", w_acc[0], 1);
      chki("sw_mem_addr", int'(w_maddr[0]), 4);
    end

    // Second tie with last grant a write: read goes first. Partial-strobe write.
    push_w(32'h100, wdat(80), 16'h00FF, 1'b1);
    push_r(32'h40, 1'b1);
    run(20, 1'b1);
    chki("tie2_counts", w_acc.size() + r_acc.size() + d_val.size(), 3);
    if (w_acc.size() == 1 && r_acc.size() == 1 && d_val.size() == 1) begin
      chki("tie2_r_cyc", r_acc[0], 1);
      chki("tie2_w_cyc", w_acc[0], 3);
      chkw("tie2_rdata", d_val[0], wdat(40));
    end

    // Streaming: 8 writes then 8 back-to-back reads with an always-ready consumer.
    add_wr_burst(32'h000, 8, 100);
    run(30, 1'b1);
    add_rd_burst(32'h000, 8);
    run(30, 1'b1);
    chki("stream_r_count", r_acc.size(), 8);
    chki("stream_d_count", d_val.size(), 8);
    if (r_acc.size() == 8 && d_val.size() == 8) begin
      chki("stream_first_accept", r_acc[0], 1);
      for (int k = 0; k < 8; k++) begin
        chki("stream_accept_cyc", r_acc[k], r_acc[0] + k);
        chki("stream_data_cyc", d_cyc[k], r_acc[0] + 2 + k);
        chkw("stream_rdata", d_val[k], wdat(100 + k));
      end
    end

    // Address wrap above the word slice, and merge of the partial-strobe write.
    push_r(32'h0001_0000, 1'b0);
    push_r(32'h100, 1'b1);
    run(20, 1'b1);
    chki("wrap_d_count", d_val.size(), 2);
    if (d_val.size() == 2) begin
      ta = wdat(0); tb = wdat(80);
      texp = {ta[DW-1:64], tb[63:0]};
      chkw("wrap_rdata", d_val[0], wdat(100));
      chkw("strobe_merge_rdata", d_val[1], texp);
    end

    // Backpressure: only two reads may issue before the consumer is ready.
    add_rd_burst(32'h000, 4);
    rdy_from = 10;
    run(40, 1'b1);
    rdy_from = 0;
    n_early = 0;
    foreach (r_acc[i]) if (r_acc[i] < 10) n_early++;
    chki("bp_reads_before_ready", n_early, 2);
    chki("bp_d_count", d_val.size(), 4);
    if (d_val.size() == 4) begin
      chki("bp_first_pop_cyc", d_cyc[0], 10);
      for (int k = 0; k < 4; k++) chkw("bp_rdata", d_val[k], wdat(100 + k));
    end

    // Read request rising mid write burst waits for the write's last beat.
    add_wr_burst(32'h200, 8, 200);
    add_rd_burst(32'h200, 2);
    r_delay = 2;
    run(40, 1'b1);
    r_delay = 0;
    chki("cont_w_count", w_acc.size(), 8);
    chki("cont_r_count", r_acc.size(), 2);
    if (w_acc.size() == 8 && r_acc.size() == 2 && d_val.size() == 2) begin
      chki("cont_w_last_cyc", w_acc[7], 8);
      chki("cont_r_first_cyc", r_acc[0], 10);
      chkw("cont_rdata0", d_val[0], wdat(200));
      chkw("cont_rdata1", d_val[1], wdat(201));
    end

    // Reset during a stalled read with the buffer full.
    add_rd_burst(32'h000, 4);
    rdy_from = 1000;
    run(6, 1'b0);
    chki("rst_mid_reads_issued", r_acc.size(), 2);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk1("rst_mid_pre_RDataValid", RDataValid, 1'b1);
    chk1("rst_mid_pre_RAddrReady", RAddrReady, 1'b0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    m_reset();
    @(negedge ACLK);
    chk1("rst_mid_RDataValid", RDataValid, 1'b0);
    chk1("rst_mid_RAddrReady", RAddrReady, 1'b0);
    chk1("rst_mid_MemCs", MemCs, 1'b0);
    chk1("rst_mid_WAddrReady", WAddrReady, 1'b0);
    model_step();
    @(posedge ACLK); #1;
    rq.delete();
    rdy_from = 0;
    add_rd_burst(32'h050, 2);
    run(20, 1'b1);
    chki("post_rst_d_count", d_val.size(), 2);
    if (d_val.size() == 2) begin
      chkw("post_rst_rdata0", d_val[0], wdat(105));
      chkw("post_rst_rdata1", d_val[1], wdat(106));
    end

    WAddrValid = 1'b0;
    RAddrValid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
